// File: rtl/guess_round_ctrl.sv
// Round sequencer for the 6-bit guess/match game: latches the answer, assembles
// serial guesses, samples the comparator's match count and tracks win/lose.
module guess_round_ctrl #(
  parameter int unsigned MAX_TRIES = 8,
  parameter int unsigned TRY_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ans_load,
  input  logic [5:0]       ans_in,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic [2:0]       count_in,
  output logic [5:0]       ans_out,
  output logic [5:0]       guess_out,
  output logic             ready,
  output logic [2:0]       last_count,
  output logic [TRY_W-1:0] tries,
  output logic             result_valid,
  output logic             win,
  output logic             lose
);

  localparam int unsigned GW = 6;
  localparam int unsigned CW = 3;
  localparam int unsigned IW = 3;

  typedef enum logic [1:0] {IDLE, COLLECT, CHECK, DONE} state_t;

  state_t            state, state_nx;
  logic [GW-2:0]     shift, shift_nx;
  logic [IW-1:0]     idx, idx_nx;
  logic [GW-1:0]     ans_nx, guess_nx, shifted;
  logic [CW-1:0]     last_nx;
  logic [TRY_W-1:0]  tries_nx, tries_inc;
  logic              rv_nx, win_nx, lose_nx, ready_nx;

  // Only the five most recent bits need keeping; the sixth completes the guess.
  assign shifted   = {shift, bit_in};
  assign tries_inc = tries + TRY_W'(1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ans_nx   = ans_out;
    guess_nx = guess_out;
    shift_nx = shift;
    idx_nx   = idx;
    last_nx  = last_count;
    tries_nx = tries;
    rv_nx    = 1'b0;
    win_nx   = win;
    lose_nx  = lose;
    if (ans_load) begin
      ans_nx   = ans_in;
      shift_nx = '0;
      idx_nx   = '0;
      last_nx  = '0;
      tries_nx = '0;
      win_nx   = 1'b0;
      lose_nx  = 1'b0;
      state_nx = COLLECT;
    end else begin
      case (state)
        IDLE: ;
        COLLECT: begin
          if (bit_valid) begin
            shift_nx = shifted[GW-2:0];
            if (idx == IW'(GW - 1)) begin
              guess_nx = shifted;
              idx_nx   = '0;
              state_nx = CHECK;
            end else begin
              idx_nx = idx + IW'(1);
            end
          end
        end
        CHECK: begin
          last_nx  = count_in;
          tries_nx = tries_inc;
          rv_nx    = 1'b1;
          if (count_in == CW'(6)) begin
            win_nx   = 1'b1;
            state_nx = DONE;
          end else if (tries_inc == TRY_W'(MAX_TRIES)) begin
            lose_nx  = 1'b1;
            state_nx = DONE;
          end else begin
            state_nx = COLLECT;
          end
        end
        DONE: ;
        default: state_nx = IDLE;
      endcase
    end
    ready_nx = (state_nx == COLLECT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ans_out      <= '0;
      guess_out    <= '0;
      shift        <= '0;
      idx          <= '0;
      last_count   <= '0;
      tries        <= '0;
      result_valid <= 1'b0;
      win          <= 1'b0;
      lose         <= 1'b0;
      ready        <= 1'b0;
    end else begin
      ans_out      <= ans_nx;
      guess_out    <= guess_nx;
      shift        <= shift_nx;
      idx          <= idx_nx;
      last_count   <= last_nx;
      tries        <= tries_nx;
      result_valid <= rv_nx;
      win          <= win_nx;
      lose         <= lose_nx;
      ready        <= ready_nx;
    end
  end

endmodule

// File: tb/tb_guess_round_ctrl.sv
// Directed bench for guess_round_ctrl with a behavioural match-count comparator.
module tb_guess_round_ctrl;

  logic       clk = 1'b0;
  logic       reset, ans_load, bit_valid, bit_in;
  logic [5:0] ans_in;
  logic [2:0] count_in;
  logic [5:0] ans_out, guess_out;
  logic       ready, result_valid, win, lose;
  logic [2:0] last_count;
  logic [3:0] tries;

  int passed = 0;
  int total  = 0;
  int rv_pulses = 0;

  always #5 clk = ~clk;

  guess_round_ctrl #(.MAX_TRIES(8), .TRY_W(4)) dut (
    .clk(clk), .reset(reset), .ans_load(ans_load), .ans_in(ans_in),
    .bit_valid(bit_valid), .bit_in(bit_in), .count_in(count_in),
    .ans_out(ans_out), .guess_out(guess_out), .ready(ready),
    .last_count(last_count), .tries(tries), .result_valid(result_valid),
    .win(win), .lose(lose)
  );

  // Environment comparator: number of equal bit positions.
  always_comb begin
    count_in = 3'd0;
    for (int i = 0; i < 6; i++)
      if (ans_out[i] == guess_out[i]) count_in = count_in + 3'd1;
  end

  always @(posedge clk) if (result_valid) rv_pulses <= rv_pulses + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_guess(input logic [5:0] g);
    for (int i = 5; i >= 0; i--) begin
      bit_valid = 1'b1;
      bit_in    = g[i];
      tick();
    end
    bit_valid = 1'b0;
  endtask

  task automatic load(input logic [5:0] a);
    ans_load = 1'b1;
    ans_in   = a;
    tick();
    ans_load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ans_load = 1'b0; ans_in = '0; bit_valid = 1'b0; bit_in = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ans",   8'(ans_out), 8'h00);
    chk("rst_guess", 8'(guess_out), 8'h00);
    chk("rst_ready", 8'(ready), 8'h0);
    chk("rst_tries", 8'(tries), 8'h0);
    chk("rst_flags", 8'({result_valid, win, lose}), 8'h0);

    // Test 1: answer 111000, guess 111111 -> 3 matches
    load(6'b111000);
    chk("t1_ans",   8'(ans_out), 8'h38);
    chk("t1_ready", 8'(ready), 8'h1);
    send_guess(6'b111111);
    chk("t1_guess", 8'(guess_out), 8'h3f);
    chk("t1_check_ready", 8'(ready), 8'h0);
    chk("t1_check_rv", 8'(result_valid), 8'h0);
    tick();
    chk("t1_rv",    8'(result_valid), 8'h1);
    chk("t1_count", 8'(last_count), 8'h3);
    chk("t1_tries", 8'(tries), 8'h1);
    chk("t1_wl",    8'({win, lose}), 8'h0);
    chk("t1_ready2", 8'(ready), 8'h1);
    tick();
    chk("t1_rv_drop", 8'(result_valid), 8'h0);

    // Test 2: winning guess, then DONE ignores bits
    send_guess(6'b111000);
    tick();
    chk("t2_rv",    8'(result_valid), 8'h1);
    chk("t2_count", 8'(last_count), 8'h6);
    chk("t2_tries", 8'(tries), 8'h2);
    chk("t2_win",   8'({win, lose}), 8'h2);
    chk("t2_ready", 8'(ready), 8'h0);
    bit_valid = 1'b1; bit_in = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    bit_valid = 1'b0;
    tick();
    chk("t2_hold_guess", 8'(guess_out), 8'h38);
    chk("t2_hold_tries", 8'(tries), 8'h2);
    chk("t2_hold_flags", 8'({result_valid, win, lose, ready}), 8'h4);

    // Test 3: eight misses -> lose
    load(6'b111000);
    chk("t3_cleared", 8'({tries, win, lose}), 8'h0);
    for (int g = 0; g < 8; g++) begin
      send_guess(6'b000111);
      tick();
      chk($sformatf("t3_count%0d", g), 8'(last_count), 8'h0);
      chk($sformatf("t3_tries%0d", g), 8'(tries), 8'(g + 1));
      chk($sformatf("t3_lose%0d", g), 8'({win, lose}), (g == 7) ? 8'h1 : 8'h0);
      chk($sformatf("t3_ready%0d", g), 8'(ready), (g == 7) ? 8'h0 : 8'h1);
    end
    send_guess(6'b111000);
    tick();
    chk("t3_done_hold", 8'({tries, win, lose}), 8'h21);

    // Test 4: partial guess discarded by reload (bit_valid in load cycle ignored)
    load(6'b101010);
    bit_valid = 1'b1;
    bit_in = 1'b1; tick();
    bit_in = 1'b0; tick();
    bit_in = 1'b1; tick();
    ans_load = 1'b1; ans_in = 6'b010101; bit_in = 1'b1;
    tick();
    ans_load = 1'b0; bit_valid = 1'b0;
    chk("t4_ans",   8'(ans_out), 8'h15);
    chk("t4_state", 8'({tries, win, lose, ready}), 8'h1);
    send_guess(6'b010101);
    chk("t4_guess", 8'(guess_out), 8'h15);
    tick();
    chk("t4_count", 8'(last_count), 8'h6);
    chk("t4_win",   8'({tries, win, lose}), 8'h6);

    // Test 5: reset mid-collect, then bits ignored in IDLE
    load(6'b111000);
    bit_valid = 1'b1; bit_in = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bit_valid = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t5_rst_out", 8'({ans_out[5:4], guess_out}), 8'h00);
    chk("t5_rst_misc", 8'({last_count, result_valid, win, lose, ready}), 8'h00);
    chk("t5_rst_tries", 8'(tries), 8'h0);
    bit_valid = 1'b1; bit_in = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    bit_valid = 1'b0;
    tick();
    chk("t5_idle_guess", 8'(guess_out), 8'h00);
    chk("t5_idle_flags", 8'({tries, result_valid, ready}), 8'h00);

    // Test 6: gaps between bits and a bit during CHECK
    load(6'b111000);
    rv_pulses = 0;
    for (int i = 5; i >= 1; i--) begin
      bit_valid = 1'b1; bit_in = (i >= 3); tick();
      bit_valid = 1'b0; tick();
    end
    chk("t6_not_yet", 8'({ready, guess_out == 6'b111000 && 1'b0}), 8'h2);
    bit_valid = 1'b1; bit_in = 1'b0; tick();
    chk("t6_guess", 8'(guess_out), 8'h38);
    bit_in = 1'b1; tick();
    bit_valid = 1'b0;
    chk("t6_count", 8'(last_count), 8'h6);
    chk("t6_win",   8'({tries, win, lose}), 8'h6);
    tick(); tick(); tick();
    chk("t6_one_pulse", 8'(rv_pulses), 8'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/guess_round_ctrl.md
Name: guess_round_ctrl

Overview:
Sequencer for the 6-bit guess/match comparator. It latches a secret answer and assembles each 6-bit guess from a serial bit stream. It presents the answer and the complete guess to the combinational comparator, samples the match count, and tracks attempts until a win (6 matches) or loss (MAX_TRIES exhausted). It sits between a serial input source and the comparator, owning its ans and a..f inputs.

Parameters:
MAX_TRIES, 8, attempts allowed per game; legal range 1..15.
TRY_W, 4, width of the attempt counter; must hold MAX_TRIES.

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset  input  1  synchronous, active-high reset.
ans_load  input  1  latch ans_in as the new answer and start a new game.
ans_in  input  6  answer value sampled when ans_load=1.
bit_valid  input  1  bit_in is valid this cycle.
bit_in  input  1  serial guess bit; first accepted bit is a, sixth is f.
count_in  input  3  match count returned by the comparator.
ans_out  output  6  latched answer driven to comparator ans.
guess_out  output  6  assembled guess to comparator; [5]=a, [4]=b, ..., [0]=f.
ready  output  1  1 only in COLLECT; guess bits are accepted.
last_count  output  3  count_in sampled on the most recent check.
tries  output  TRY_W  completed attempts in the current game.
result_valid  output  1  one-cycle pulse when last_count/tries update.
win  output  1  sticky; set when a check returns 6.
lose  output  1  sticky; set when tries reaches MAX_TRIES without a win.

Behaviour:
- Reset is synchronous and active-high. While reset=1 at an edge: state=IDLE; ans_out, guess_out, last_count, tries, result_valid, win, lose, internal shift register and bit index all return to 0. ready=0.
- Priority: reset > ans_load > all other activity.
- States: IDLE, COLLECT, CHECK, DONE. ready is decoded from state (COLLECT).
- ans_load=1 in any state: ans_out<=ans_in; tries, last_count, win, lose, bit index and shift register are cleared; state<=COLLECT. Any partial guess is discarded, and bit_valid in the same cycle is ignored.
- IDLE: waits for ans_load; bit_valid is ignored.
- COLLECT: on each bit_valid=1, shift<={shift[4:0],bit_in} and bit index +1. Cycles with bit_valid=0 change nothing.
  - On the sixth accepted bit: guess_out<={shift[4:0],bit_in}, bit index<=0, state<=CHECK. guess_out is otherwise stable, so the comparator never sees a partial guess.
- CHECK (exactly one cycle; bit_valid ignored): at the edge leaving CHECK, last_count<=count_in, tries<=tries+1, result_valid<=1. Then:
  - if count_in==6: win<=1, state<=DONE;
  - else if tries+1==MAX_TRIES: lose<=1, state<=DONE;
  - else state<=COLLECT.
  - count_in of 7 is treated as a non-win.
- result_valid is 1 for exactly the one cycle after CHECK; 0 otherwise.
- Latency: sixth bit accepted at edge k -> guess_out valid after k; result_valid, last_count, tries and win/lose valid after edge k+1. ready returns to 1 after k+1 if the game continues.
- DONE: win/lose, tries and last_count hold; bit_valid is ignored; only ans_load or reset leave DONE.
- win and lose are never both 1. tries never exceeds MAX_TRIES and does not wrap.

Test Plan:
1. Reset, then ans_load with ans_in=111000, then bits 1,1,1,1,1,1 -> guess_out=111111; one cycle later last_count=3, tries=1, result_valid pulses once, win=0, lose=0, ready=1.
2. Continue with bits 1,1,1,0,0,0 -> last_count=6, tries=2, win=1, ready=0. Further bit_valid pulses leave all outputs unchanged.
3. ans=111000, eight guesses of 000111 (default MAX_TRIES=8) -> each check gives last_count=0; after the 8th, tries=8, lose=1, win=0, state DONE.
4. ans=101010, send 3 bits, then pulse ans_load with ans_in=010101 -> tries=0, partial guess discarded; the next 6 bits 010101 give last_count=6 and win=1.
5. Mid-COLLECT (4 bits sent) assert reset for 1 cycle -> all outputs 0, ready=0. Subsequent bit_valid is ignored until ans_load.
6. ans=111000, bits 1,1,1,0,0,0 with bit_valid=0 gaps between bits, plus bit_valid=1 during CHECK -> gaps and CHECK-cycle bits are ignored, the single guess gives last_count=6, and result_valid pulses exactly once.
